// File: rtl/phase_tag_arbiter.sv
// Per-channel tag FIFOs feeding a round-robin arbiter and a single held output word.
// Latency: a tag strobed in cycle N is presented on word_out in cycle N+2 when the path is idle.
// Backpressure: the held word freezes until word_ready; a push into a full FIFO is dropped and counted.

module ptag_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic         clk_sample_120,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk_sample_120) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_sample_120) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

module phase_tag_arbiter #(
    parameter int NUM_CH           = 2,
    parameter int PHASE_COUNT_SIZE = 28,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk_sample_120,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [NUM_CH*PHASE_COUNT_SIZE-1:0] tag_in,
    input  logic [NUM_CH-1:0]                  tag_valid,
    output logic [31:0]                        word_out,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [NUM_CH*8-1:0]                drop_count,
    output logic [NUM_CH-1:0]                  fifo_empty
);
    typedef enum logic {S_EMPTY, S_HELD} state_t;

    state_t                      state;
    logic [NUM_CH-1:0]           full;
    logic [NUM_CH-1:0]           push;
    logic [NUM_CH-1:0]           pop;
    logic [NUM_CH-1:0]           drop;
    logic [NUM_CH-1:0]           ovf;
    logic [PHASE_COUNT_SIZE-1:0] head [NUM_CH];
    logic [7:0]                  drop_cnt [NUM_CH];
    logic [1:0]                  last_grant;
    logic [1:0]                  grant;
    logic                        found;
    logic                        load;
    logic                        sel_ovf;
    logic [PHASE_COUNT_SIZE-1:0] sel_tag;
    int                          cand;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pop[c]  = load && (grant == 2'(c));
        assign push[c] = tag_valid[c] && enable && (!full[c] || pop[c]);
        assign drop[c] = tag_valid[c] && enable && full[c] && !pop[c];
        assign drop_count[c*8 +: 8] = drop_cnt[c];

        ptag_fifo #(
            .W     (PHASE_COUNT_SIZE),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_sample_120 (clk_sample_120),
            .rst            (rst),
            .push           (push[c]),
            .pop            (pop[c]),
            .din            (tag_in[c*PHASE_COUNT_SIZE +: PHASE_COUNT_SIZE]),
            .dout           (head[c]),
            .empty          (fifo_empty[c]),
            .full           (full[c])
        );
    end

    // Search starts one past the last winner; only registered FIFO state is seen.
    always_comb begin
        grant   = last_grant;
        found   = 1'b0;
        cand    = 0;
        sel_ovf = 1'b0;
        sel_tag = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && cand == c && !fifo_empty[c]) begin
                    found = 1'b1;
                    grant = 2'(c);
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == 2'(c)) begin
                sel_ovf = ovf[c];
                sel_tag = head[c];
            end
        end
    end

    assign load       = (state == S_EMPTY || word_ready) && found;
    assign word_valid = (state == S_HELD);

    always_ff @(posedge clk_sample_120) begin
        if (rst) begin
            state      <= S_EMPTY;
            word_out   <= '0;
            last_grant <= 2'(NUM_CH - 1);
        end else if (load) begin
            state      <= S_HELD;
            word_out   <= {grant, sel_ovf, 1'b0, 28'(sel_tag)};
            last_grant <= grant;
        end else if (word_ready) begin
            state      <= S_EMPTY;
        end
    end

    // A drop in the load cycle keeps the flag set for the next word.
    always_ff @(posedge clk_sample_120) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                ovf[c]      <= 1'b0;
                drop_cnt[c] <= '0;
            end else begin
                if (drop[c])
                    ovf[c] <= 1'b1;
                else if (pop[c])
                    ovf[c] <= 1'b0;
                if (drop[c] && drop_cnt[c] != 8'hFF)
                    drop_cnt[c] <= drop_cnt[c] + 8'd1;
            end
        end
    end
endmodule
